// File: rtl/riscv_gpio_irq.sv
// rtl/riscv_gpio_irq.sv - GPIO peripheral with direction, atomic writes and edge interrupts
//
// Purpose: bus-mapped GPIO slave. Per-pin output value and output enable,
// set/clear/toggle aliases of the output register, synchronised inputs and
// rise/fall edge detection with sticky pending bits folded into one
// registered level interrupt.
// Optional feature macro: RISCV_GPIO_DEBOUNCE_EN adds a per-pin debounce
// stage of DEB_CYCLES clk cycles between the synchroniser and IN/edge logic.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   sel, enable, write   bus select, access phase, direction (1=write)
//   addr, wdata, rdata   byte address (addr[11:0] decoded), write/read data
//   gpio_o, gpio_oe      pin output value and output enable
//   gpio_i               asynchronous pin inputs
//   irq                  registered |(PEND & IE)
module riscv_gpio_irq #(
    parameter int XLEN        = 32,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sel,
    input  logic             enable,
    input  logic             write,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             irq
);

    localparam logic [11:0] OFF_OUT  = 12'h000;
    localparam logic [11:0] OFF_SET  = 12'h004;
    localparam logic [11:0] OFF_CLR  = 12'h008;
    localparam logic [11:0] OFF_TGL  = 12'h00C;
    localparam logic [11:0] OFF_DIR  = 12'h010;
    localparam logic [11:0] OFF_IN   = 12'h014;
    localparam logic [11:0] OFF_IE   = 12'h018;
    localparam logic [11:0] OFF_RISE = 12'h01C;
    localparam logic [11:0] OFF_FALL = 12'h020;
    localparam logic [11:0] OFF_PEND = 12'h024;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] in_q;
    logic             irq_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_db;
    logic [WIDTH-1:0] edge_set;
    logic             wr;
    logic [11:0]      off;
    logic [WIDTH-1:0] wd;
    logic             unused_bits;

    assign wr  = sel & enable & write;
    assign off = addr[11:0];
    assign wd  = wdata[WIDTH-1:0];
    assign in_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

`ifdef RISCV_GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] deb_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    // A pin's counter runs only while in_s disagrees with the debounced value;
    // the value flips on the DEB_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            deb_q <= '0;
            for (int p = 0; p < WIDTH; p++) cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < WIDTH; p++) begin
                if (in_s[p] != deb_q[p]) begin
                    if (cnt_q[p] == CNT_LAST) begin
                        deb_q[p] <= in_s[p];
                        cnt_q[p] <= '0;
                    end else begin
                        cnt_q[p] <= cnt_q[p] + 1'b1;
                    end
                end else begin
                    cnt_q[p] <= '0;
                end
            end
        end
    end

    assign in_db       = deb_q;
    assign unused_bits = ^{addr[XLEN-1:12], wdata};
`else
    assign in_db       = in_s;
    assign unused_bits = ^{addr[XLEN-1:12], wdata, 32'(DEB_CYCLES)};
`endif

    assign edge_set = (in_db & ~in_q & rise_q) | (~in_db & in_q & fall_q);

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        pend_d = pend_q;
        if (wr) begin
            case (off)
                OFF_OUT:  out_d  = wd;
                OFF_SET:  out_d  = out_q | wd;
                OFF_CLR:  out_d  = out_q & ~wd;
                OFF_TGL:  out_d  = out_q ^ wd;
                OFF_DIR:  dir_d  = wd;
                OFF_IE:   ie_d   = wd;
                OFF_RISE: rise_d = wd;
                OFF_FALL: fall_d = wd;
                OFF_PEND: pend_d = pend_q & ~wd;
                default:  ;
            endcase
        end
        // New edges are OR-ed in after the w1c so a coincident edge survives.
        pend_d = pend_d | edge_set;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q  <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            in_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
            in_q   <= in_db;
            irq_q  <= |(pend_q & ie_q);
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL: rdata = XLEN'(out_q);
            OFF_DIR:  rdata = XLEN'(dir_q);
            OFF_IN:   rdata = XLEN'(in_db);
            OFF_IE:   rdata = XLEN'(ie_q);
            OFF_RISE: rdata = XLEN'(rise_q);
            OFF_FALL: rdata = XLEN'(fall_q);
            OFF_PEND: rdata = XLEN'(pend_q);
            default:  rdata = '0;
        endcase
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_riscv_gpio_irq.sv
// tb/tb_riscv_gpio_irq.sv - directed self-checking bench for riscv_gpio_irq
module tb_riscv_gpio_irq;

    localparam int XLEN = 32;
    localparam int WIDTH = 32;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             sel, enable, write;
    logic [XLEN-1:0]  addr, wdata, rdata;
    logic [WIDTH-1:0] gpio_o, gpio_oe, gpio_i;
    logic             irq;

    int n_total = 0;
    int n_pass  = 0;
    logic [XLEN-1:0] rd;

    riscv_gpio_irq #(
        .XLEN(XLEN), .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .gpio_o(gpio_o), .gpio_oe(gpio_oe), .gpio_i(gpio_i), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write lands on the next posedge; returns 1 time unit after it.
    task automatic bus_write(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; enable = 1'b0; write = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [XLEN-1:0] a, output logic [XLEN-1:0] d);
        sel = 1'b1; enable = 1'b0; write = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick(2);
        n_total++;
        if (gpio_o !== 32'h0) $display("FAIL reset_gpio_o got %h want 0", gpio_o); else n_pass++;
        n_total++;
        if (gpio_oe !== 32'h0) $display("FAIL reset_gpio_oe got %h want 0", gpio_oe); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
        rstn = 1'b1;
        tick(1);
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reset_pend got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_out_atomic;
        bus_write(32'h00, 32'h0000_00F0);
        bus_write(32'h04, 32'h0000_0001);
        n_total++;
        if (gpio_o !== 32'h0000_00F1) $display("FAIL out_set got %h want 000000f1", gpio_o); else n_pass++;
        bus_write(32'h08, 32'h0000_0010);
        n_total++;
        if (gpio_o !== 32'h0000_00E1) $display("FAIL out_clr got %h want 000000e1", gpio_o); else n_pass++;
        bus_write(32'h0C, 32'h0000_0003);
        n_total++;
        if (gpio_o !== 32'h0000_00E2) $display("FAIL out_tgl got %h want 000000e2", gpio_o); else n_pass++;
        bus_read(32'h00, rd);
        n_total++;
        if (rd !== 32'h0000_00E2) $display("FAIL out_read got %h want 000000e2", rd); else n_pass++;
        bus_read(32'h0C, rd);
        n_total++;
        if (rd !== 32'h0000_00E2) $display("FAIL tgl_alias_read got %h want 000000e2", rd); else n_pass++;
    endtask

    task automatic test_dir_in;
        bus_write(32'h10, 32'hFFFF_0000);
        n_total++;
        if (gpio_oe !== 32'hFFFF_0000) $display("FAIL dir_oe got %h want ffff0000", gpio_oe); else n_pass++;
        gpio_i = 32'h0000_005A;
        tick(1);
        bus_read(32'h14, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL in_early got %h want 0", rd); else n_pass++;
        tick(SYNC_STAGES);
        bus_read(32'h14, rd);
        n_total++;
        if (rd !== 32'h0000_005A) $display("FAIL in_read got %h want 0000005a", rd); else n_pass++;
        gpio_i = 32'h0;
        tick(SYNC_STAGES + 2);
    endtask

    task automatic test_rise_irq;
        bus_write(32'h1C, 32'h1);
        bus_write(32'h18, 32'h1);
        gpio_i[0] = 1'b1;
        tick(SYNC_STAGES + 1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL rise_irq_early got %b want 0", irq); else n_pass++;
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL rise_pend got %h want 1", rd); else n_pass++;
        tick(1);
        n_total++;
        if (irq !== 1'b1) $display("FAIL rise_irq got %b want 1", irq); else n_pass++;
        bus_write(32'h24, 32'h1);
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL pend_w1c got %h want 0", rd); else n_pass++;
        tick(1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_fall_ie;
        bus_write(32'h20, 32'h4);
        bus_write(32'h18, 32'h0);
        gpio_i[2] = 1'b1;
        tick(SYNC_STAGES + 3);
        gpio_i[2] = 1'b0;
        tick(SYNC_STAGES + 3);
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h4) $display("FAIL fall_pend got %h want 4", rd); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL fall_irq_masked got %b want 0", irq); else n_pass++;
        bus_write(32'h18, 32'h4);
        tick(1);
        n_total++;
        if (irq !== 1'b1) $display("FAIL ie_enable_irq got %b want 1", irq); else n_pass++;
        bus_write(32'h24, 32'h4);
        bus_write(32'h18, 32'h0);
    endtask

    task automatic test_w1c_collision;
        // Pin 0 is high; take it low (no FALL enabled on bit 0) then re-rise.
        gpio_i[0] = 1'b0;
        tick(SYNC_STAGES + 3);
        gpio_i[0] = 1'b1;
        tick(SYNC_STAGES);
        // The PEND set from this rise happens on the same edge as the w1c.
        bus_write(32'h24, 32'h1);
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL w1c_collide got %h want 1", rd); else n_pass++;
        bus_write(32'h24, 32'h1);
        bus_read(32'h40, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL unmapped_read got %h want 0", rd); else n_pass++;
        bus_write(32'h40, 32'hFFFF_FFFF);
        n_total++;
        if (gpio_o !== 32'h0000_00E2 || gpio_oe !== 32'hFFFF_0000)
            $display("FAIL unmapped_write got out=%h oe=%h want 000000e2/ffff0000", gpio_o, gpio_oe);
        else n_pass++;
        bus_read(32'h18, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL unmapped_write_ie got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus_write(32'h24, 32'hFFFF_FFFF);
        bus_write(32'h18, 32'h1);
        gpio_i[0] = 1'b0;
        tick(SYNC_STAGES + 2);
        gpio_i[0] = 1'b1;
        tick(SYNC_STAGES + 2);
        n_total++;
        if (irq !== 1'b1) $display("FAIL mid_pre_irq got %b want 1", irq); else n_pass++;
        rstn = 1'b0;
        tick(1);
        n_total++;
        if (gpio_o !== 32'h0 || gpio_oe !== 32'h0 || irq !== 1'b0)
            $display("FAIL mid_reset got out=%h oe=%h irq=%b want 0/0/0", gpio_o, gpio_oe, irq);
        else n_pass++;
        bus_read(32'h14, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL mid_reset_in got %h want 0", rd); else n_pass++;
        rstn = 1'b1;
        tick(1);
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL post_reset_pend got %h want 0", rd); else n_pass++;
    endtask

`ifdef RISCV_GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        gpio_i = 32'h0;
        bus_write(32'h1C, 32'h8);
        tick(SYNC_STAGES + DEB_CYCLES + 4);
        bus_write(32'h24, 32'hFFFF_FFFF);
        gpio_i[3] = 1'b1;
        tick(10);
        gpio_i[3] = 1'b0;
        tick(SYNC_STAGES + DEB_CYCLES + 4);
        bus_read(32'h14, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL deb_glitch_in got %h want 0", rd); else n_pass++;
        bus_read(32'h24, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL deb_glitch_pend got %h want 0", rd); else n_pass++;
        gpio_i[3] = 1'b1;
        tick(20 + SYNC_STAGES);
        bus_read(32'h14, rd);
        n_total++;
        if (rd !== 32'h8) $display("FAIL deb_level_in got %h want 8", rd); else n_pass++;
    endtask
`endif

    initial begin
        rstn = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
        addr = '0; wdata = '0; gpio_i = '0;
        #1;
        test_reset;
        test_out_atomic;
        test_dir_in;
        test_rise_irq;
        test_fall_ie;
        test_w1c_collision;
        test_reset_mid;
`ifdef RISCV_GPIO_DEBOUNCE_EN
        test_debounce;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
